// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_scan
//  Purpose  : Registered N-to-2^N one-hot decoder with an autonomous scan
//             mode. Direct mode decodes address `a` with one cycle of
//             latency. Scan mode steps the one-hot output round-robin through
//             the active channels, dwelling `div`+1 cycles on each.
//
//  Parameters
//    AW     : address width, output width is 2**AW
//    DIV_W  : width of the dwell divisor
//
//  Ports
//    clk    in   1        : clock, all state changes on the rising edge
//    rst_n  in   1        : synchronous active-low reset
//    en     in   1        : block enable, 0 forces IDLE and all-zero output
//    mode   in   1        : 0 = direct decode, 1 = scan
//    a      in   AW       : direct-mode address
//    div    in   DIV_W    : dwell length minus 1 (scan mode)
//    mask   in   2**AW    : per-channel scan enable (1 = active)
//    bcode  out  2**AW    : registered one-hot output, or all zero
//    idx    out  AW       : index currently decoded
//    tick   out  1        : one-cycle pulse when scan advances idx
//    wrap   out  1        : one-cycle pulse when the advance lands on an
//                           index <= the previous one
//
//  Build option
//    DECODER_SCAN_MASK_EN : when defined, `mask` selects the active channels
//                           and blanks bcode. When undefined, `mask` is
//                           ignored and all channels are active.
//
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_scan #(
    parameter int AW    = 3,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [AW-1:0]    a,
    input  logic [DIV_W-1:0] div,
    input  logic [2**AW-1:0] mask,
    output logic [2**AW-1:0] bcode,
    output logic [AW-1:0]    idx,
    output logic             tick,
    output logic             wrap
);

    localparam int c_num_ch = 2**AW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_num_ch-1:0] r_bcode;
    logic [AW-1:0]       r_idx;
    logic                r_tick;
    logic                r_wrap;
    logic [DIV_W-1:0]    r_pre;
    // Set while scanning with no active channel; the first edge that sees
    // an active channel again reloads the lowest one, exactly like entry.
    logic                r_need_load;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [c_num_ch-1:0] w_bcode_nxt;
    logic [AW-1:0]       w_idx_nxt;
    logic                w_tick_nxt;
    logic                w_wrap_nxt;
    logic [DIV_W-1:0]    w_pre_nxt;
    logic                w_need_load_nxt;

    logic [c_num_ch-1:0] w_mask;
    logic [AW-1:0]       w_lowest;
    logic [AW-1:0]       w_next;
    logic                w_load;

    function automatic logic [c_num_ch-1:0] f_onehot(input logic [AW-1:0] i);
        logic [c_num_ch-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Effective channel mask
    // ------------------------------------------------------------------
`ifdef DECODER_SCAN_MASK_EN
    assign w_mask = mask;
`else
    // OR-ing with all ones keeps the port referenced while forcing every
    // channel active.
    assign w_mask = mask | {c_num_ch{1'b1}};
`endif

    // Lowest active channel: scan from the top so the last hit wins.
    always_comb begin
        w_lowest = '0;
        for (int i = c_num_ch - 1; i >= 0; i--) begin
            if (w_mask[i]) begin
                w_lowest = AW'(i);
            end
        end
    end

    // Next active channel strictly above r_idx, modulo 2**AW. The offset
    // k = c_num_ch lands back on r_idx itself, so a single active channel
    // re-selects itself. Searching offsets from far to near lets the
    // nearest active channel overwrite the others.
    always_comb begin
        logic [AW-1:0] v_cand;
        w_next = r_idx;
        v_cand = r_idx;
        for (int k = c_num_ch; k >= 1; k--) begin
            v_cand = r_idx + AW'(k);
            if (w_mask[v_cand]) begin
                w_next = v_cand;
            end
        end
    end

    assign w_load = (r_state != S_SCAN) || r_need_load;

    // ------------------------------------------------------------------
    // FSM: next state depends only on en/mode, from any state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = S_IDLE;
        if (en) begin
            w_state_nxt = mode ? S_SCAN : S_DIRECT;
        end
    end

    // Output/datapath values for the state being entered at this edge.
    always_comb begin
        w_bcode_nxt     = '0;
        w_idx_nxt       = r_idx;
        w_tick_nxt      = 1'b0;
        w_wrap_nxt      = 1'b0;
        w_pre_nxt       = '0;
        w_need_load_nxt = 1'b0;

        case (w_state_nxt)
            S_DIRECT: begin
                w_bcode_nxt = f_onehot(a);
                w_idx_nxt   = a;
            end

            S_SCAN: begin
                if (w_mask == '0) begin
                    // Nothing to scan: blank, freeze idx and prescaler.
                    w_pre_nxt       = r_pre;
                    w_need_load_nxt = 1'b1;
                end else if (w_load) begin
                    w_idx_nxt   = w_lowest;
                    w_bcode_nxt = f_onehot(w_lowest);
                end else if (r_pre == div) begin
                    // Equality compare: if div drops below the count, the
                    // prescaler runs on through DIV_W wrap-around.
                    w_idx_nxt   = w_next;
                    w_bcode_nxt = f_onehot(w_next) & w_mask;
                    w_tick_nxt  = 1'b1;
                    w_wrap_nxt  = (w_next <= r_idx);
                end else begin
                    w_pre_nxt   = r_pre + 1'b1;
                    w_bcode_nxt = f_onehot(r_idx) & w_mask;
                end
            end

            default: begin
                // IDLE: outputs zero, idx held, prescaler cleared.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bcode     <= '0;
            r_idx       <= '0;
            r_tick      <= 1'b0;
            r_wrap      <= 1'b0;
            r_pre       <= '0;
            r_need_load <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bcode     <= w_bcode_nxt;
            r_idx       <= w_idx_nxt;
            r_tick      <= w_tick_nxt;
            r_wrap      <= w_wrap_nxt;
            r_pre       <= w_pre_nxt;
            r_need_load <= w_need_load_nxt;
        end
    end

    assign bcode = r_bcode;
    assign idx   = r_idx;
    assign tick  = r_tick;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_scan
//  Purpose  : Self-checking bench for decoder_scan (AW=3, DIV_W=16).
//             Direct-mode vectors come from a table; scan, masking, mode
//             switching and reset sequences are hand-written.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  a;
    logic [15:0] div;
    logic [7:0]  mask;
    logic [7:0]  bcode;
    logic [2:0]  idx;
    logic        tick;
    logic        wrap;

    int n_checks = 0;
    int n_errors = 0;

    decoder_scan #(
        .AW    (3),
        .DIV_W (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .a     (a),
        .div   (div),
        .mask  (mask),
        .bcode (bcode),
        .idx   (idx),
        .tick  (tick),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] a;
        logic [7:0] eb;
        logic [2:0] ei;
    } dvec_t;

    dvec_t tbl[11];

    // Advance one edge and settle; inputs changed afterwards apply next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eb,
                         input logic [2:0] ei, input logic et, input logic ew);
        n_checks++;
        if (bcode !== eb || idx !== ei || tick !== et || wrap !== ew) begin
            n_errors++;
            $display("FAIL %s: got bcode=%h idx=%0d tick=%b wrap=%b, expected bcode=%h idx=%0d tick=%b wrap=%b",
                     name, bcode, idx, tick, wrap, eb, ei, et, ew);
        end
    endtask

    initial begin
        logic [7:0] sb[4];
        logic [2:0] si[4];
        logic       st[4];
        logic       sw[4];
        int         ch;
        int         ph;
        logic       et;

        // Direct-mode table: each row is checked one edge after it is applied.
        tbl[0]  = '{1'b1, 1'b0, 3'd5, 8'h20, 3'd5};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 8'h01, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 3'd1, 8'h02, 3'd1};
        tbl[3]  = '{1'b1, 1'b0, 3'd2, 8'h04, 3'd2};
        tbl[4]  = '{1'b1, 1'b0, 3'd3, 8'h08, 3'd3};
        tbl[5]  = '{1'b1, 1'b0, 3'd4, 8'h10, 3'd4};
        tbl[6]  = '{1'b1, 1'b0, 3'd5, 8'h20, 3'd5};
        tbl[7]  = '{1'b1, 1'b0, 3'd6, 8'h40, 3'd6};
        tbl[8]  = '{1'b1, 1'b0, 3'd7, 8'h80, 3'd7};
        tbl[9]  = '{1'b0, 1'b0, 3'd3, 8'h00, 3'd7};   // disable: blank, idx held
        tbl[10] = '{1'b1, 1'b0, 3'd2, 8'h04, 3'd2};

        // ---------------- 1. reset ----------------
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; a = 3'd0; div = 16'd2; mask = 8'hFF;
        step();
        check("reset_c1", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        check("reset_c2", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check("reset_release", 8'h01, 3'd0, 1'b0, 1'b0);

        // ---------------- 2. direct decode table ----------------
        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; a = tbl[i].a;
            step();
            check($sformatf("direct_%0d", i), tbl[i].eb, tbl[i].ei, 1'b0, 1'b0);
        end

        // ---------------- 3. full scan, div=2 ----------------
        mode = 1'b1; div = 16'd2; mask = 8'hFF;
        for (int n = 0; n < 27; n++) begin
            step();
            ch = (n / 3) % 8;
            ph = n % 3;
            et = (ph == 0) && (n > 0);
            check($sformatf("scan_%0d", n), 8'h01 << ch, 3'(ch), et, et && (ch == 0));
        end

        // ---------------- 4. masked scan, div=0 ----------------
        en = 1'b0;
        step();
        check("idle_before_mask", 8'h00, 3'(ch), 1'b0, 1'b0);
        en = 1'b1; mode = 1'b1; div = 16'd0; mask = 8'hA4;
`ifdef DECODER_SCAN_MASK_EN
        sb[0] = 8'h04; si[0] = 3'd2; st[0] = 1'b0; sw[0] = 1'b0;
        sb[1] = 8'h20; si[1] = 3'd5; st[1] = 1'b1; sw[1] = 1'b0;
        sb[2] = 8'h80; si[2] = 3'd7; st[2] = 1'b1; sw[2] = 1'b0;
        sb[3] = 8'h04; si[3] = 3'd2; st[3] = 1'b1; sw[3] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            check($sformatf("mask_seq_%0d", n), sb[n], si[n], st[n], sw[n]);
        end
`else
        for (int n = 0; n < 9; n++) begin
            step();
            check($sformatf("nomask_seq_%0d", n), 8'h01 << (n % 8), 3'(n % 8),
                  n > 0, n == 8);
        end
`endif

        // ---------------- 5. empty mask ----------------
        en = 1'b0;
        step();
        en = 1'b1; mode = 1'b1; div = 16'd2; mask = 8'h00;
`ifdef DECODER_SCAN_MASK_EN
        // idx left at 2 by the masked sequence and held through IDLE.
        for (int n = 0; n < 50; n++) begin
            step();
            check($sformatf("mask0_%0d", n), 8'h00, 3'd2, 1'b0, 1'b0);
        end
        mask = 8'h10;
        step();
        check("mask10_load", 8'h10, 3'd4, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            step();
            check("mask10_dwell_a", 8'h10, 3'd4, 1'b0, 1'b0);
            step();
            check("mask10_dwell_b", 8'h10, 3'd4, 1'b0, 1'b0);
            step();
            check("mask10_self_tick", 8'h10, 3'd4, 1'b1, 1'b1);
        end
`else
        div = 16'd0;
        step();
        check("mask0_ignored_entry", 8'h01, 3'd0, 1'b0, 1'b0);
        step();
        check("mask0_ignored_step", 8'h02, 3'd1, 1'b1, 1'b0);
`endif

        // ---------------- 6. mid-operation changes ----------------
        en = 1'b0;
        step();
        en = 1'b1; mode = 1'b1; div = 16'd0; mask = 8'hFF;
        step();
        check("mid_entry", 8'h01, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("mid_run_%0d", k), 8'h01 << k, 3'(k), 1'b1, 1'b0);
        end
        mode = 1'b0; a = 3'd1;
        step();
        check("mid_to_direct", 8'h02, 3'd1, 1'b0, 1'b0);
        mode = 1'b1; div = 16'd3;
        step();
        check("mid_rescan", 8'h01, 3'd0, 1'b0, 1'b0);
        step();
        check("mid_dwell", 8'h01, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        check("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check("post_reset_entry", 8'h01, 3'd0, 1'b0, 1'b0);
        for (int n = 1; n <= 3; n++) begin
            step();
            check($sformatf("post_reset_dwell_%0d", n), 8'h01, 3'd0, 1'b0, 1'b0);
        end
        step();
        check("post_reset_advance", 8'h02, 3'd1, 1'b1, 1'b0);

        en = 1'b0;
        step();
        check("final_disable", 8'h00, 3'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot decoder with an autonomous scan mode. In direct mode it decodes an input address with one cycle of latency. In scan mode an internal prescaler and index counter step the one-hot output through the enabled channels in round-robin order. It sits between control logic and multiplexed outputs such as LED/7-segment digit enables, and generalises the fixed 2-to-4 and 3-to-8 decoders.

## Interface
- `AW`, default 3: address width; output width is 2**AW.
- `DIV_W`, default 16: width of the dwell divisor.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: block enable; 0 forces IDLE and an all-zero output.
- `mode`  in  1: 0 = direct decode, 1 = scan.
- `a`  in  AW: address for direct mode.
- `div`  in  DIV_W: dwell length minus 1, in clk cycles, for scan mode.
- `mask`  in  2**AW: per-channel scan enable (1 = channel active).
- `bcode`  out  2**AW: registered one-hot output, or all zero.
- `idx`  out  AW: index currently decoded.
- `tick`  out  1: one-cycle pulse when scan advances `idx`.
- `wrap`  out  1: one-cycle pulse when scan advance wraps to a lower index.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE, `bcode`=0, `idx`=0, `tick`=0, `wrap`=0, prescaler=0. Reset has priority over every other input.
- State machine has three states: IDLE, DIRECT, SCAN. These transitions are evaluated every edge, in any state:
  - `en`=0 -> IDLE.
  - `en`=1 & `mode`=0 -> DIRECT.
  - `en`=1 & `mode`=1 -> SCAN.
- **IDLE**
  - `bcode`=0, `tick`=`wrap`=0.
  - `idx` holds its value.
  - Prescaler is held at 0.
- **DIRECT**
  - Each edge: `bcode` <= one-hot(`a`), `idx` <= `a`.
  - Prescaler is held at 0; `tick`=`wrap`=0.
- **SCAN entry** (from IDLE or DIRECT):
  - `idx` <= lowest active channel; prescaler <= 0.
  - `bcode` <= one-hot of that channel.
- **SCAN steady state**
  - Prescaler counts 0..`div`.
  - When prescaler==`div`: prescaler <= 0, `idx` <= next active channel above `idx`, modulo 2**AW.
  - `tick`=1 for that one cycle, aligned with the new `idx`.
  - `wrap`=1 in the same cycle if the new `idx` is less than or equal to the old one.
  - `bcode` always equals one-hot(`idx`) & `mask`, registered.
- **SCAN edge cases**
  - A single active channel re-selects itself on each advance, so `tick` and `wrap` both pulse.
  - `mask`=0: `bcode`=0, `idx` and prescaler hold, and `tick`/`wrap` stay 0. When a bit later sets, the next edge loads the lowest active channel, as on entry.
  - `mask` changes take effect at the next advance, except for `bcode` masking, which applies at the next edge.
  - `div` is sampled every cycle. If `div` is lowered below the current count, the prescaler advances at wrap-around of DIV_W (no early advance).
  - `div`=0: advance every cycle.

## Timing
- Direct decode latency: 1 cycle from `a` to `bcode`.
- Scan entry latency: 1 cycle from `en`&`mode` sampled to the first `bcode`.
- Dwell per channel: exactly `div`+1 cycles.
- Deassertion: `en`=0 or `rst_n`=0 gives `bcode`=0 at the next edge.
- `tick` and `wrap` are registered and high for exactly one cycle.
- No combinational path from any input to any output.

## Configuration
- `DECODER_SCAN_MASK_EN` defined: `mask` controls channel skipping and output blanking as described above.
- `DECODER_SCAN_MASK_EN` undefined:
  - `mask` port remains but is ignored; all 2**AW channels are always active.
  - Scan runs 0..2**AW-1 in order, and `wrap` pulses on the advance from 2**AW-1 to 0.

## Test plan
1. Reset: `en`=1, `mode`=1, `rst_n`=0 for 2 cycles -> `bcode`=0, `idx`=0, `tick`=`wrap`=0. Release -> `bcode`=8'h01 one cycle later.
2. Direct (AW=3): `mode`=0, `a`=5 -> `bcode`=8'h20 next cycle. Sweep `a`=0..7 -> each one-hot appears 1 cycle later. `en`=0 -> `bcode`=0 next cycle.
3. Scan: `div`=2, `mask`=8'hFF -> `bcode` steps 01,02,...,80, each held 3 cycles, with `tick` every 3rd cycle. On 80->01, `wrap`=1 together with `tick`.
4. Masked scan (macro defined): `div`=0, `mask`=8'hA4 -> `bcode` sequence 04,20,80,04, with `wrap` on the 80->04 step. Macro undefined: full 01..80 sequence.
5. `mask`=0 in SCAN -> `bcode`=0 and no `tick` for 50 cycles. Set `mask`=8'h10 -> `bcode`=8'h10 next cycle, then `tick`=`wrap`=1 every `div`+1 cycles.
6. Mid-operation changes:
   - At `idx`=6 in scan, set `mode`=0, `a`=1 -> `bcode`=8'h02 next cycle.
   - Return to `mode`=1 -> restarts at the lowest active channel.
   - Pulse `rst_n`=0 mid-dwell -> all outputs 0 next edge, and the prescaler restarts.
